// File: rtl/cpu_pkg.sv
// Shared encodings for the mini-CPU control sequencer: opcodes, FSM states,
// ALU operation codes and instruction field positions.
package cpu_pkg;

    localparam int OP_MSB = 7;
    localparam int OP_LSB = 5;
    localparam int RD_MSB = 4;
    localparam int RD_LSB = 3;
    localparam int RS_MSB = 2;
    localparam int RS_LSB = 1;

    typedef logic [2:0] opcode_t;

    localparam opcode_t OP_ADD  = 3'b000;
    localparam opcode_t OP_SUB  = 3'b001;
    localparam opcode_t OP_AND  = 3'b010;
    localparam opcode_t OP_OR   = 3'b011;
    localparam opcode_t OP_LD   = 3'b100;
    localparam opcode_t OP_ST   = 3'b101;
    localparam opcode_t OP_BEQZ = 3'b110;
    localparam opcode_t OP_HALT = 3'b111;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_OR  = 2'b11;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    // ALU opcodes share the top bit 0, so their low bits double as the ALU code.
    function automatic logic is_alu_op(opcode_t op);
        return (op[2] == 1'b0);
    endfunction

    function automatic logic is_mem_op(opcode_t op);
        return (op == OP_LD) || (op == OP_ST);
    endfunction

endpackage

// File: rtl/cpu_ctrl_seq_if.sv
// Control bus between the sequencer (master) and the datapath (slave).
// CPU_CTRL_PERF_EN adds the cycle_cnt/instret performance counter outputs.
interface cpu_ctrl_seq_if;
    logic [7:0] instr;
    logic       rd1_zero;
    logic       mem_ready;
    logic       ir_load;
    logic       pc_en;
    logic       pc_sel;
    logic       reg_we;
    logic       wb_sel;
    logic [1:0] alu_op;
    logic       mem_req;
    logic       mem_we;
    logic       mdr_load;
    logic       halted;
    logic [2:0] state_out;
`ifdef CPU_CTRL_PERF_EN
    logic [15:0] cycle_cnt;
    logic [15:0] instret;

    modport master (
        input  instr, rd1_zero, mem_ready,
        output ir_load, pc_en, pc_sel, reg_we, wb_sel, alu_op,
               mem_req, mem_we, mdr_load, halted, state_out,
               cycle_cnt, instret
    );
    modport slave (
        output instr, rd1_zero, mem_ready,
        input  ir_load, pc_en, pc_sel, reg_we, wb_sel, alu_op,
               mem_req, mem_we, mdr_load, halted, state_out,
               cycle_cnt, instret
    );
`else
    modport master (
        input  instr, rd1_zero, mem_ready,
        output ir_load, pc_en, pc_sel, reg_we, wb_sel, alu_op,
               mem_req, mem_we, mdr_load, halted, state_out
    );
    modport slave (
        output instr, rd1_zero, mem_ready,
        input  ir_load, pc_en, pc_sel, reg_we, wb_sel, alu_op,
               mem_req, mem_we, mdr_load, halted, state_out
    );
`endif
endinterface

// File: rtl/cpu_ctrl_perf.sv
// Free-running performance counters: active cycles and retired instructions.
// Only instantiated when CPU_CTRL_PERF_EN is defined.
module cpu_ctrl_perf (
    input  logic        clk,
    input  logic        reset,
    input  logic        cnt_en_i,
    input  logic        ret_en_i,
    output logic [15:0] cycle_cnt_o,
    output logic [15:0] instret_o
);
    logic [15:0] cycle_q, cycle_d;
    logic [15:0] instret_q, instret_d;

    // Both counters wrap naturally at 16 bits.
    always_comb begin
        cycle_d   = cnt_en_i ? cycle_q + 16'd1 : cycle_q;
        instret_d = ret_en_i ? instret_q + 16'd1 : instret_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cycle_q   <= '0;
            instret_q <= '0;
        end else begin
            cycle_q   <= cycle_d;
            instret_q <= instret_d;
        end
    end

    assign cycle_cnt_o = cycle_q;
    assign instret_o   = instret_q;
endmodule

// File: rtl/cpu_ctrl_seq.sv
// Multi-cycle control FSM for the 8-bit mini CPU (FETCH/DECODE/EXEC/MEM/WB/HALT).
// CPU_CTRL_PERF_EN adds cycle and retired-instruction counters via cpu_ctrl_perf.
module cpu_ctrl_seq
    import cpu_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    cpu_ctrl_seq_if.master bus
);
    state_t  state_q, state_d;
    opcode_t op;

    assign op = bus.instr[OP_MSB:OP_LSB];

    // Register fields are consumed by the datapath, not by the sequencer.
    logic unused_fields;
    assign unused_fields = ^bus.instr[RD_MSB:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= S_FETCH;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d      = state_q;
        bus.ir_load  = 1'b0;
        bus.pc_en    = 1'b0;
        bus.pc_sel   = 1'b0;
        bus.reg_we   = 1'b0;
        bus.wb_sel   = 1'b0;
        bus.alu_op   = ALU_ADD;
        bus.mem_req  = 1'b0;
        bus.mem_we   = 1'b0;
        bus.mdr_load = 1'b0;
        bus.halted   = 1'b0;

        case (state_q)
            S_FETCH: state_d = S_DECODE;
            S_DECODE: begin
                if (op == OP_HALT)     state_d = S_HALT;
                else if (is_mem_op(op)) state_d = S_MEM;
                else                   state_d = S_EXEC;
            end
            S_EXEC:  state_d = is_alu_op(op) ? S_WB : S_FETCH;
            S_MEM: begin
                if (bus.mem_ready) state_d = (op == OP_LD) ? S_WB : S_FETCH;
            end
            S_WB:    state_d = S_FETCH;
            S_HALT:  state_d = S_HALT;
            default: state_d = S_FETCH;
        endcase

        // Enables are masked during reset so nothing fires while state is forced.
        if (!reset) begin
            case (state_q)
                S_FETCH: bus.ir_load = 1'b1;
                S_EXEC: begin
                    if (is_alu_op(op)) begin
                        bus.alu_op = op[1:0];
                    end else if (op == OP_BEQZ) begin
                        bus.pc_en  = 1'b1;
                        bus.pc_sel = bus.rd1_zero;
                    end
                end
                S_MEM: begin
                    bus.mem_req = 1'b1;
                    bus.mem_we  = (op == OP_ST);
                    if (bus.mem_ready) begin
                        if (op == OP_LD)      bus.mdr_load = 1'b1;
                        else if (op == OP_ST) bus.pc_en    = 1'b1;
                    end
                end
                S_WB: begin
                    bus.reg_we = 1'b1;
                    bus.wb_sel = (op == OP_LD);
                    bus.pc_en  = 1'b1;
                end
                S_HALT:  bus.halted = 1'b1;
                default: ;
            endcase
        end
    end

    assign bus.state_out = state_q;

`ifdef CPU_CTRL_PERF_EN
    cpu_ctrl_perf u_perf (
        .clk         (clk),
        .reset       (reset),
        .cnt_en_i    (state_q != S_HALT),
        .ret_en_i    (bus.pc_en),
        .cycle_cnt_o (bus.cycle_cnt),
        .instret_o   (bus.instret)
    );
`endif
endmodule
